// File: rtl/frame_streamer_if.sv
// Memory read port and pixel stream bundle for frame_streamer.
// master: the streamer side (drives reads and the stream).
// slave:  the environment side (memory model and stream consumer).
interface frame_streamer_if #(
    parameter int N1 = 320,
    parameter int N0 = 240,
    parameter int DW = 32
);
    localparam int A1W = $clog2(N1);
    localparam int A0W = $clog2(N0);

    // memory read port
    logic           rdEn;
    logic [A1W-1:0] rdAddr1;
    logic [A0W-1:0] rdAddr0;
    logic [DW-1:0]  rdData;

    // pixel stream
    logic [DW-1:0]  pixOut;
    logic           pixValid;
    logic           pixReady;
    logic           sof;
    logic           eol;
    logic           eof;

    modport master (
        output rdEn, rdAddr1, rdAddr0, pixOut, pixValid, sof, eol, eof,
        input  rdData, pixReady
    );

    modport slave (
        input  rdEn, rdAddr1, rdAddr0, pixOut, pixValid, sof, eol, eof,
        output rdData, pixReady
    );
endinterface

// File: rtl/frame_streamer.sv
// Raster readout of the processed image bank as a valid/ready pixel stream.
// Reads are issued at most one per cycle; a 2-entry buffer soaks up the
// 1-cycle memory latency so the stream runs at full rate under any
// backpressure pattern without ever overflowing.
module frame_streamer #(
    parameter int N1 = 320,
    parameter int N0 = 240,
    parameter int DW = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    output logic            busy,
    output logic            frameDone,
    frame_streamer_if.master bus
);
    localparam int A1W = $clog2(N1);
    localparam int A0W = $clog2(N0);
    localparam int EW  = DW + 3;   // pixel plus {sof, eol, eof}

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0]     state;
    logic [A1W-1:0] addr1;
    logic [A0W-1:0] addr0;

    // read issued last cycle and the markers that belong to it
    logic           inflight;
    logic [2:0]     infl_mk;

    // 2-entry output buffer
    logic [EW-1:0]  fifo_q [2];
    logic           wr_ptr;
    logic           rd_ptr;
    logic [1:0]     occ;

    logic           last_col;
    logic           last_row;
    logic           first_px;
    logic           rd_en;
    logic           pix_valid;
    logic           push;
    logic           pop;
    logic [EW-1:0]  head;

    assign last_col  = (addr0 == A0W'(N0 - 1));
    assign last_row  = (addr1 == A1W'(N1 - 1));
    assign first_px  = (addr0 == '0) && (addr1 == '0);

    assign head      = fifo_q[rd_ptr];
    assign pix_valid = (occ != 2'd0);
    assign pop       = pix_valid & bus.pixReady;
    assign push      = inflight;

    // Only issue when the entry it will land in is guaranteed free next
    // cycle: buffered + in flight, less what leaves now, must stay <= 1.
    assign rd_en = (state == RUN) &&
                   (({1'b0, occ} + {2'b0, inflight}) <= (3'd1 + {2'b0, pop}));

    // Frame sequencer and raster address counters
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            addr1 <= '0;
            addr0 <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= RUN;
                        addr1 <= '0;
                        addr0 <= '0;
                    end
                end
                RUN: begin
                    if (rd_en) begin
                        if (last_col) begin
                            addr0 <= '0;
                            if (last_row) begin
                                // counters park at the origin once the final read is out
                                addr1 <= '0;
                                state <= DRAIN;
                            end else begin
                                addr1 <= addr1 + A1W'(1);
                            end
                        end else begin
                            addr0 <= addr0 + A0W'(1);
                        end
                    end
                end
                DRAIN: begin
                    // the eof pixel is always the last one left in the buffer
                    if (pop && head[DW]) state <= DONE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Delay markers by the memory latency so they line up with rdData
    always_ff @(posedge clk) begin
        if (!rst) begin
            inflight <= 1'b0;
            infl_mk  <= 3'b000;
        end else begin
            inflight <= rd_en;
            infl_mk  <= {first_px, last_col, last_col & last_row};
        end
    end

    // Output buffer: push returning data, pop on handshake
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 2; i++) fifo_q[i] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            occ    <= 2'd0;
        end else begin
            if (push) begin
                fifo_q[wr_ptr] <= {infl_mk, bus.rdData};
                wr_ptr         <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            occ <= occ + 2'(push) - 2'(pop);
        end
    end

    assign bus.rdEn     = rd_en;
    assign bus.rdAddr1  = addr1;
    assign bus.rdAddr0  = addr0;

    // stream outputs are forced quiet whenever there is nothing to offer
    assign bus.pixValid = pix_valid;
    assign bus.pixOut   = pix_valid ? head[DW-1:0] : '0;
    assign bus.sof      = pix_valid & head[DW+2];
    assign bus.eol      = pix_valid & head[DW+1];
    assign bus.eof      = pix_valid & head[DW];

    assign busy      = (state != IDLE);
    assign frameDone = (state == DONE);
endmodule
